ws2812b_rx: RTL

Single-wire WS2812B NRZ receiver, the companion to our ws2812b transmitter. It measures high-pulse widths on the input line, decodes 24-bit GRB pixel words (MSB first), and presents them on a valid/ready stream. It also flags the end-of-frame reset gap (latch) and protocol errors. Used as a loopback checker on the LED peripheral and as a standalone strip-sniffer input.

---
 rtl/ws2812b_pkg.sv | 25 ++
 rtl/ws2812b_rx_pulse_meas.sv | 81 ++++++++
 rtl/ws2812b_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: timing defaults, ns-to-cycle conversion and FSM states shared
// by the WS2812B transmitter and receiver.
package ws2812b_pkg;

    localparam int CLOCK_MHZ_DEF   = 64;
    localparam int T_MIN_NS_DEF    = 150;
    localparam int T_THRESH_NS_DEF = 600;
    localparam int T_MAX_NS_DEF    = 2000;
    localparam int T_RESET_US_DEF  = 50;

    localparam int WORD_BITS = 24;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    // Cycle count for a duration in ns at the given clock, truncated.
    function automatic int ns_to_cycles(input int ns, input int clock_mhz);
        return (clock_mhz * ns) / 1000;
    endfunction

endpackage

// File: rtl/ws2812b_rx_pulse_meas.sv
// ws2812b_rx_pulse_meas: synchronises the line, detects edges and times each
// level with one saturating counter, producing per-pulse classification strobes.
// With WS2812B_RX_FORWARD_EN defined, the synchronised line is also exported.
module ws2812b_rx_pulse_meas #(
    parameter int MIN_CYC    = 9,
    parameter int THRESH_CYC = 38,
    parameter int MAX_CYC    = 128,
    parameter int RESET_CYC  = 3200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
`ifdef WS2812B_RX_FORWARD_EN
    output logic line,
`endif
    output logic rise,
    output logic bit_valid,
    output logic bit_val,
    output logic glitch,
    output logic too_long,
    output logic reset_gap
);

    localparam int CNT_W = $clog2(RESET_CYC + 1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYC);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall;

`ifdef WS2812B_RX_FORWARD_EN
    assign line = sync2_q;
`endif

    // Synchroniser shift, edge detect, level timer and pulse classification.
    // cnt_q holds how many cycles the previous level lasted when an edge is seen.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        fall    = ~sync2_q & prev_q;

        if (rise || fall) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == RESET_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        glitch    = fall && (cnt_q < MIN_C);
        bit_valid = fall && (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
        bit_val   = (cnt_q >= THRESH_C);
        // Still high with MAX cycles already counted: the pulse is now too long.
        too_long  = sync2_q && prev_q && (cnt_q == MAX_C);
        // Fires once, on the cycle the low count reaches RESET.
        reset_gap = !sync2_q && !prev_q && (cnt_q == RESET_C - CNT_W'(1));
    end

    // Synchroniser and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B NRZ receiver. Decodes 24-bit GRB words MSB first onto a
// valid/ready stream, pulses latch on the frame gap, flags sticky errors.
// Optional feature macro WS2812B_RX_FORWARD_EN: only the first word of each
// frame is streamed and the rest of the frame is forwarded on dout.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int CLOCK_MHZ   = CLOCK_MHZ_DEF,
    parameter int T_MIN_NS    = T_MIN_NS_DEF,
    parameter int T_THRESH_NS = T_THRESH_NS_DEF,
    parameter int T_MAX_NS    = T_MAX_NS_DEF,
    parameter int T_RESET_US  = T_RESET_US_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic        latch,
    output logic        error,
    output logic        overflow,
    input  logic        err_clr,
    output logic        dout
);

    localparam int MIN_CYC    = ns_to_cycles(T_MIN_NS, CLOCK_MHZ);
    localparam int THRESH_CYC = ns_to_cycles(T_THRESH_NS, CLOCK_MHZ);
    localparam int MAX_CYC    = ns_to_cycles(T_MAX_NS, CLOCK_MHZ);
    localparam int RESET_CYC  = ns_to_cycles(T_RESET_US * 1000, CLOCK_MHZ);
    localparam logic [4:0] LAST_BIT = 5'(WORD_BITS - 1);

    logic rise, bit_valid, bit_val, glitch, too_long, reset_gap;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [22:0] shift_q, shift_d;
    logic        got_bit_q, got_bit_d;
    logic        latch_q, latch_d;
    logic [23:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        overflow_q, overflow_d;
    logic        err_set, ovf_set, word_done, frame_end, deliver;
    logic [23:0] new_word;

    assign new_word = {shift_q, bit_val};

`ifdef WS2812B_RX_FORWARD_EN
    logic line;
    logic fwd_q, fwd_d;
    logic dout_q, dout_d;
`endif

    ws2812b_rx_pulse_meas #(
        .MIN_CYC    (MIN_CYC),
        .THRESH_CYC (THRESH_CYC),
        .MAX_CYC    (MAX_CYC),
        .RESET_CYC  (RESET_CYC)
    ) u_meas (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
`ifdef WS2812B_RX_FORWARD_EN
        .line      (line),
`endif
        .rise      (rise),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .glitch    (glitch),
        .too_long  (too_long),
        .reset_gap (reset_gap)
    );

    // Frame FSM: bit assembly, word completion, gap/latch and protocol errors.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        got_bit_d = got_bit_q;
        latch_d   = 1'b0;
        err_set   = 1'b0;
        word_done = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            RESYNC: begin
                if (reset_gap) state_d = IDLE;
            end
            IDLE: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (too_long || glitch) begin
                    // Abandon the frame; only a full gap re-arms decoding.
                    err_set   = 1'b1;
                    state_d   = RESYNC;
                    bit_cnt_d = '0;
                    got_bit_d = 1'b0;
                    frame_end = 1'b1;
                end else if (bit_valid) begin
                    state_d   = LOW;
                    got_bit_d = 1'b1;
                    shift_d   = new_word[22:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (reset_gap) begin
                    state_d   = IDLE;
                    latch_d   = got_bit_q;
                    got_bit_d = 1'b0;
                    frame_end = 1'b1;
                    if (bit_cnt_q != '0) begin
                        err_set   = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
            end
            default: state_d = RESYNC;
        endcase
    end

`ifdef WS2812B_RX_FORWARD_EN
    assign deliver = word_done & ~fwd_q;
    assign dout    = dout_q;

    // Forwarding window opens after the frame's first word and closes at the gap or an error.
    always_comb begin
        fwd_d = fwd_q;
        if (word_done) fwd_d = 1'b1;
        if (frame_end) fwd_d = 1'b0;
        dout_d = fwd_q & line;
    end

    // Forwarding registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            fwd_q  <= fwd_d;
            dout_q <= dout_d;
        end
    end
`else
    assign deliver = word_done;
    assign dout    = 1'b0;
`endif

    // Output buffer with handshake, plus sticky error/overflow flags (set beats clear).
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        error_d    = error_q;
        overflow_d = overflow_q;
        ovf_set    = 1'b0;
        if (valid_q && ready) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = new_word;
                valid_d = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (err_clr) begin
            error_d    = 1'b0;
            overflow_d = 1'b0;
        end
        if (err_set) error_d = 1'b1;
        if (ovf_set) overflow_d = 1'b1;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RESYNC;
            bit_cnt_q  <= '0;
            got_bit_q  <= 1'b0;
            latch_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            got_bit_q  <= got_bit_d;
            latch_q    <= latch_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

    // Bit shift register; bit_cnt alone marks how much of it is meaningful.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign latch    = latch_q;
    assign error    = error_q;
    assign overflow = overflow_q;

endmodule
